// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 active-low keypad, debounces full scans, reports single presses + 8-digit history.
// Latency: press accepted DEBOUNCE_SCANS scans after onset, key_valid one cycle later; no backpressure (pulse output).
module keypad_scanner #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [3:0] dig7,
  output logic [3:0] dig6,
  output logic [3:0] dig5,
  output logic [3:0] dig4,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  // Scan result kind doubles as the saturated low-bit count: 0 none, 1 single, 2 multi.
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx;
  logic             sample, scan_end;

  logic [1:0]       acc_cnt, acc_cnt_nxt;
  logic [3:0]       acc_code, acc_code_nxt;
  logic [2:0]       col_lows, cnt_sum;
  logic [3:0]       col_code;
  logic             col_hit;

  logic [1:0]       cand_kind;
  logic [3:0]       cand_code;
  logic [STB_W-1:0] stable_cnt, stable_nxt;
  logic             same_result, settled;

  logic             accept, release_ok;
  logic [3:0]       hist [8];

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      col_idx <= 2'd0;
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign col      = ~(4'b0001 << col_idx);
  assign sample   = (div_q == DIV_LAST);
  assign scan_end = sample && (col_idx == 2'd3);

  // Rows are scanned top to bottom so the last low row wins the recorded code.
  always_comb begin
    col_lows = 3'd0;
    col_code = 4'h0;
    col_hit  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        col_lows = col_lows + 3'd1;
        col_code = key_map(2'(r), col_idx);
        col_hit  = 1'b1;
      end
    end
    cnt_sum      = {1'b0, acc_cnt} + col_lows;
    acc_cnt_nxt  = (cnt_sum >= 3'd2) ? RES_MULTI : cnt_sum[1:0];
    acc_code_nxt = col_hit ? col_code : acc_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      if (col_idx == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_cnt  <= acc_cnt_nxt;
        acc_code <= acc_code_nxt;
      end
    end
  end

  always_comb begin
    same_result = (acc_cnt_nxt == cand_kind) &&
                  ((acc_cnt_nxt != RES_SINGLE) || (acc_code_nxt == cand_code));
    if (acc_cnt_nxt == RES_MULTI)
      stable_nxt = '0;
    else if (same_result)
      stable_nxt = (stable_cnt == STB_MAX) ? STB_MAX : stable_cnt + 1'b1;
    else
      stable_nxt = STB_W'(1);
    settled = (stable_nxt == STB_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_kind  <= RES_NONE;
      cand_code  <= 4'h0;
      stable_cnt <= '0;
    end else if (scan_end) begin
      cand_kind  <= acc_cnt_nxt;
      cand_code  <= acc_code_nxt;
      stable_cnt <= stable_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // No rollover: while PRESSED only a settled all-released scan returns to IDLE.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    release_ok = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if ((acc_cnt_nxt == RES_SINGLE) && settled) begin
            state_d = PRESSED;
            accept  = 1'b1;
          end
        end
        PRESSED: begin
          if ((acc_cnt_nxt == RES_NONE) && settled) begin
            state_d    = IDLE;
            release_ok = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      for (int i = 0; i < 8; i++) hist[i] <= 4'h0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= acc_code_nxt;
        key_down <= 1'b1;
        hist[0]  <= acc_code_nxt;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
      end else if (release_ok) begin
        key_down <= 1'b0;
      end
    end
  end

  assign dig0 = hist[0];
  assign dig1 = hist[1];
  assign dig2 = hist[2];
  assign dig3 = hist[3];
  assign dig4 = hist[4];
  assign dig5 = hist[5];
  assign dig6 = hist[6];
  assign dig7 = hist[7];

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model drives rows from col strobes; a monitor scores key_valid pulses.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_down;
  logic [3:0] dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0;
  logic [31:0] dig_all;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .dig7(dig7), .dig6(dig6), .dig5(dig5), .dig4(dig4),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0)
  );

  assign dig_all = {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};

  // Pressed keys, bit index r*4+c; a pressed key pulls its row low while its column is strobed.
  logic [15:0] keys = 16'h0;
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] hist;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_hist = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          valid_seen = 0;

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] m;
    m = 16'h0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input logic [3:0] k);
    exp_t e;
    model_hist = {model_hist[27:0], k};
    e.code = k;
    e.hist = model_hist;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, key_valid === 1'b1}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (key_down !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, key_down}, 32'd0);
  endtask

  // Monitor: every key_valid cycle must match the oldest outstanding expected press.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      exp_t e;
      valid_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: key_code %h dig %h, no press expected", key_code, dig_all);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e.code || dig_all !== e.hist || key_down !== 1'b1) begin
          errors++;
          $display("FAIL press: got code %h dig %h down %b, expected code %h dig %h down 1",
                   key_code, dig_all, key_down, e.code, e.hist);
        end
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [3:0] col_seq [4];
    col_seq[0] = 4'b1101;
    col_seq[1] = 4'b1011;
    col_seq[2] = 4'b0111;
    col_seq[3] = 4'b1110;

    // Reset and column walk
    cycles(2);
    rst = 1'b0;
    check("reset_col", {28'd0, col}, 32'h0000000E);
    check("reset_flags", {26'd0, key_code, key_valid, key_down}, 32'd0);
    check("reset_dig", dig_all, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycles(8);
      check("col_step", {28'd0, col}, {28'd0, col_seq[i]});
    end

    // Key '5' held 200 cycles
    start = valid_seen;
    keys = kbit(1, 1);
    expect_key(4'h5);
    cycles(60);
    check("key5_not_early", valid_seen - start, 0);
    wait_valid("key5_valid", 72);
    check("key5_down", {31'd0, key_down}, 32'd1);
    cycles(200 - 2 - (valid_seen > start ? 60 : 0) - 10);
    keys = 16'h0;
    cycles(32);
    check("key5_down_after_release", {31'd0, key_down}, 32'd1);
    wait_release("key5_release");
    check("key5_code_holds", {28'd0, key_code}, 32'h5);

    // Bounce on '9'
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? kbit(2, 2) : 16'h0;
      cycles(32);
    end
    start = valid_seen;
    keys = kbit(2, 2);
    cycles(60);
    check("bounce_no_valid", valid_seen - start, 0);
    expect_key(4'h9);
    wait_valid("key9_valid", 80);
    keys = 16'h0;
    wait_release("key9_release");

    // Two keys '1' + 'D', then release 'D'
    start = valid_seen;
    keys = kbit(0, 0) | kbit(3, 3);
    cycles(320);
    check("multi_no_valid", valid_seen - start, 0);
    check("multi_key_down", {31'd0, key_down}, 32'd0);
    keys = kbit(0, 0);
    expect_key(4'h1);
    wait_valid("key1_after_multi", 140);
    keys = 16'h0;
    wait_release("key1_release");

    // Sequence 1..9 with full releases
    for (int k = 1; k <= 9; k++) begin
      keys = kbit((k - 1) / 3, (k - 1) % 3);
      expect_key(4'(k));
      wait_valid("seq_valid", 140);
      cycles(10);
      keys = 16'h0;
      wait_release("seq_release");
    end
    check("seq_history", dig_all, 32'h23456789);

    // 'A' held, reset while down, re-accept
    keys = kbit(0, 3);
    expect_key(4'hA);
    wait_valid("keyA_valid", 140);
    check("keyA_down", {31'd0, key_down}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hist = 32'h0;
    check("midreset_flags", {26'd0, key_code, key_valid, key_down}, 32'd0);
    check("midreset_dig", dig_all, 32'd0);
    check("midreset_col", {28'd0, col}, 32'h0000000E);
    start = valid_seen;
    expect_key(4'hA);
    wait_valid("keyA_reaccept", 140);
    check("keyA_one_pulse", valid_seen - start, 1);
    check("keyA_dig0", {28'd0, dig0}, 32'hA);
    keys = 16'h0;
    wait_release("keyA_release");

    cycles(4);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 8-digit display driver. It strobes the 4 columns of a 4x4 matrix keypad one at a time (Pmod KYPD style, active-low), reads the 4 rows, debounces the result and reports single key presses as 4-bit hex codes.
- Each accepted key is also shifted into an 8-digit history. That history connects directly to the display's dig7..dig0 inputs.

Parameters:
- SCAN_DIV, 5000, clk cycles each column is driven; minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- row  input  4  keypad rows, active-low (board pull-ups); asynchronous to clk
- col  output  4  keypad column strobes, active-low; exactly one bit low at all times
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when a new press is accepted
- key_down  output  1  high while an accepted key is held
- dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0  output  4 each  key history; dig0 is the newest

Behaviour:
- Reset values:
  - col=4'b1110
  - key_code=0, key_valid=0, key_down=0
  - all dig* = 0
  - column index, divider, stable counter and candidate registers cleared
  - FSM in IDLE
- Reset mid-scan or mid-press takes effect on the next clock. No key_valid is emitted because of reset.
- Row sync: row passes through a 2-flop synchroniser before any use.
- Column scan:
  - Divider counts 0..SCAN_DIV-1. Column index c advances 0->1->2->3->0 when the divider wraps.
  - col = ~(4'b0001 << c).
  - Synchronised rows are sampled on the divider's last cycle (SCAN_DIV-1) of each column window. This leaves SCAN_DIV-3 cycles of settle.
  - Full scan period = 4*SCAN_DIV cycles.
- Key map (row r top->bottom, col c left->right):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Per-scan accumulation:
  - Count low row bits across the 4 samples (saturate at 2).
  - Record the code of the last low bit seen.
- Scan evaluation, on the c=3 sample cycle. Scan result is one of:
  - NONE: count 0
  - SINGLE(k): count 1
  - MULTI: count >= 2
- Debounce (stable_cnt, saturating at DEBOUNCE_SCANS):
  - Result equal to previous scan result: stable_cnt+1.
  - Otherwise: stable_cnt=1 and the new result is stored.
  - MULTI always forces stable_cnt=0.
- FSM IDLE:
  - SINGLE(k) with stable_cnt reaching DEBOUNCE_SCANS -> go to PRESSED.
  - On that transition: key_code<=k, key_down<=1, dig history shifts (dig7 drops, dig_i<=dig_{i-1}, dig0<=k).
  - key_valid pulses for exactly one cycle, the cycle after the evaluation.
- FSM PRESSED:
  - NONE stable for DEBOUNCE_SCANS -> go to IDLE, key_down<=0.
  - SINGLE of a different key or MULTI: stay in PRESSED, no new press reported. The user must release first; there is no rollover.
- Latency: key held steadily from the start of scan n is accepted at the end of scan n+DEBOUNCE_SCANS-1, with key_valid one cycle later.
- key_code holds its value after release. It changes only on an accepted press.
- Bounce: any glitch that changes the scan result restarts the count.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=3; scan = 32 cycles):
- Reset: rst high 2 cycles, then release.
  - col=1110 after reset; col steps 1101, 1011, 0111, 1110 at 8-cycle intervals.
  - All outputs 0.
- Key '5' (row1 low while col1 low) held 200 cycles.
  - Exactly one key_valid pulse, within 4 scans (128 cycles) + 4 cycles; key_code=5, dig0=5, others 0.
  - key_down=1 until 3 clean scans after release.
- Bounce: key '9' toggled each scan for 4 scans, then held.
  - No key_valid during toggling; one pulse 3 scans after the hold starts; key_code=9.
- Two keys: '1' and 'D' pressed together for 10 scans.
  - No key_valid, key_down=0.
  - Release 'D' only: '1' is accepted after 3 scans.
- Press-release sequence 1,2,3,4,5,6,7,8,9, each with a full release in between.
  - Result dig7..dig0 = 2,3,4,5,6,7,8,9; digit 1 has shifted out.
- Press 'A', then assert rst for 1 cycle while key_down=1.
  - Next cycle: all outputs 0, col=1110.
  - Key still held: re-accepted after 3 scans, one new key_valid, dig0=A.
